// File: rtl/mips_core_pkg.sv
// ============================================================================
// Module      : mips_core_pkg
// Description : Shared types and constants for the MIPS core front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_core_pkg;

    localparam int BRQ_DEPTH_DEFAULT = 4;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    function automatic logic outcome_to_bit(input BranchOutcome outcome);
        return (outcome == TAKEN);
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_resolve_queue.sv
// ============================================================================
// Module      : branch_resolve_queue
// Description : In-order queue of fetch predictions retired at branch
//               resolution; emits gshare training updates and GHR recovery.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_queue
    import mips_core_pkg::*;
#(
    parameter int DEPTH      = BRQ_DEPTH_DEFAULT,
    parameter int ADDR_WIDTH = 26,
    parameter int HIST_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_pred_valid,
    input  logic [ADDR_WIDTH-1:0]     i_pred_pc,
    input  logic                      i_pred_taken,
    input  logic [HIST_WIDTH-1:0]     i_pred_hist,
    output logic                      o_pred_ready,
    input  logic                      i_res_valid,
    input  logic                      i_res_taken,
    input  logic                      i_flush,
    output logic                      o_upd_valid,
    output logic [ADDR_WIDTH-1:0]     o_upd_pc,
    output logic                      o_upd_pred_taken,
    output logic                      o_upd_correct,
    output logic                      o_mispredict,
    output logic [HIST_WIDTH-1:0]     o_recover_hist,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic                      o_res_err
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic                  taken;
        logic [HIST_WIDTH-1:0] hist;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    entry_t          w_head_ent;
    logic            w_full;
    logic            w_res;
    logic            w_correct;
    logic            w_mispred;
    logic            w_push;
    logic [HIST_WIDTH-1:0] w_recover;

    assign w_head_ent = r_mem[r_head];
    assign w_full     = (r_count == c_CNT_W'(DEPTH));
    assign w_res      = i_res_valid && (r_count != '0) && !i_flush;
    assign w_correct  = (w_head_ent.taken == outcome_to_bit(BranchOutcome'(i_res_taken)));
    assign w_mispred  = w_res && !w_correct;
    // Pushes alongside a mispredict are wrong-path and must not enter the queue.
    assign w_push     = i_pred_valid && !w_full && !i_flush && !w_mispred;
    assign w_recover  = (w_head_ent.hist << 1) | {{(HIST_WIDTH-1){1'b0}}, i_res_taken};

    assign o_pred_ready = !w_full;
    assign o_count      = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= '{pc: i_pred_pc, taken: i_pred_taken, hist: i_pred_hist};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head           <= '0;
            r_tail           <= '0;
            r_count          <= '0;
            o_upd_valid      <= 1'b0;
            o_upd_pc         <= '0;
            o_upd_pred_taken <= 1'b0;
            o_upd_correct    <= 1'b0;
            o_mispredict     <= 1'b0;
            o_recover_hist   <= '0;
            o_res_err        <= 1'b0;
        end else begin
            o_upd_valid  <= 1'b0;
            o_mispredict <= 1'b0;
            o_res_err    <= 1'b0;
            if (i_flush) begin
                r_count <= '0;
                r_head  <= r_tail;
            end else begin
                if (w_res) begin
                    o_upd_valid      <= 1'b1;
                    o_upd_pc         <= w_head_ent.pc;
                    o_upd_pred_taken <= w_head_ent.taken;
                    o_upd_correct    <= w_correct;
                    o_mispredict     <= !w_correct;
                    o_recover_hist   <= w_recover;
                    r_head           <= r_head + 1'b1;
                end
                if (i_res_valid && (r_count == '0)) begin
                    o_res_err <= 1'b1;
                end
                if (w_mispred) begin
                    r_count <= '0;
                    r_tail  <= r_head + 1'b1;
                end else begin
                    r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_res);
                    r_tail  <= r_tail + c_PTR_W'(w_push);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
// ============================================================================
// Module      : tb_branch_resolve_queue
// Description : Self-checking bench for branch_resolve_queue (directed plus
//               randomized traffic against a queue-based reference model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve_queue;

    localparam int DEPTH      = 4;
    localparam int ADDR_WIDTH = 26;
    localparam int HIST_WIDTH = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   pred_valid = 1'b0;
    logic [ADDR_WIDTH-1:0]  pred_pc = '0;
    logic                   pred_taken = 1'b0;
    logic [HIST_WIDTH-1:0]  pred_hist = '0;
    logic                   pred_ready;
    logic                   res_valid = 1'b0;
    logic                   res_taken = 1'b0;
    logic                   flush = 1'b0;
    logic                   upd_valid;
    logic [ADDR_WIDTH-1:0]  upd_pc;
    logic                   upd_pred_taken;
    logic                   upd_correct;
    logic                   mispredict;
    logic [HIST_WIDTH-1:0]  recover_hist;
    logic [$clog2(DEPTH):0] count;
    logic                   res_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [ADDR_WIDTH-1:0] pc;
        logic                  taken;
        logic [HIST_WIDTH-1:0] hist;
    } model_ent_t;

    always #5 clk = ~clk;

    branch_resolve_queue #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .HIST_WIDTH (HIST_WIDTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_pred_valid     (pred_valid),
        .i_pred_pc        (pred_pc),
        .i_pred_taken     (pred_taken),
        .i_pred_hist      (pred_hist),
        .o_pred_ready     (pred_ready),
        .i_res_valid      (res_valid),
        .i_res_taken      (res_taken),
        .i_flush          (flush),
        .o_upd_valid      (upd_valid),
        .o_upd_pc         (upd_pc),
        .o_upd_pred_taken (upd_pred_taken),
        .o_upd_correct    (upd_correct),
        .o_mispredict     (mispredict),
        .o_recover_hist   (recover_hist),
        .o_count          (count),
        .o_res_err        (res_err)
    );

    // Advance one clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pred_valid = 1'b0;
        res_valid  = 1'b0;
        flush      = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic push_one(input logic [ADDR_WIDTH-1:0] pc, input logic tk,
                            input logic [HIST_WIDTH-1:0] h);
        pred_valid = 1'b1; pred_pc = pc; pred_taken = tk; pred_hist = h;
        step();
        pred_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({count, pred_ready, upd_valid, mispredict, res_err} !== {3'd0, 1'b1, 3'b000}) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got count=%0d ready=%b upd=%b misp=%b err=%b expected 0/1/0/0/0",
                         i, count, pred_ready, upd_valid, mispredict, res_err);
            end
        end
    endtask

    task automatic test_single();
        push_one(26'h40, 1'b1, 4'b0101);
        res_valid = 1'b1; res_taken = 1'b1;
        step();
        res_valid = 1'b0;
        checks++;
        if ({upd_valid, upd_pc, upd_correct, mispredict, count} !== {1'b1, 26'h40, 1'b1, 1'b0, 3'd0}) begin
            failures++;
            $display("FAIL single_resolve got v=%b pc=%h ok=%b misp=%b count=%0d expected 1/40/1/0/0",
                     upd_valid, upd_pc, upd_correct, mispredict, count);
        end
        step();
        checks++;
        if (upd_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_pulse_width got upd_valid=%b expected 0", upd_valid);
        end
    endtask

    task automatic test_fill_wrap();
        for (int i = 0; i < DEPTH; i++) push_one(26'h100 + 26'(i), 1'(i), 4'(i));
        checks++;
        if ({count, pred_ready} !== {3'd4, 1'b0}) begin
            failures++;
            $display("FAIL fill_full got count=%0d ready=%b expected 4/0", count, pred_ready);
        end
        push_one(26'h3AB, 1'b0, 4'hF);
        checks++;
        if (count !== 3'd4) begin
            failures++;
            $display("FAIL push_when_full got count=%0d expected 4", count);
        end
        res_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            res_taken = 1'(i);
            step();
            checks++;
            if ({upd_valid, upd_pc, upd_correct, count} !== {1'b1, 26'h100 + 26'(i), 1'b1, 3'(DEPTH - 1 - i)}) begin
                failures++;
                $display("FAIL fifo_order idx=%0d got v=%b pc=%h ok=%b count=%0d expected pc=%h",
                         i, upd_valid, upd_pc, upd_correct, count, 26'h100 + 26'(i));
            end
        end
        res_valid = 1'b0;
        push_one(26'h200, 1'b0, 4'h3);
        res_valid = 1'b1; res_taken = 1'b0;
        step();
        res_valid = 1'b0;
        checks++;
        if ({upd_valid, upd_pc, upd_correct} !== {1'b1, 26'h200, 1'b1}) begin
            failures++;
            $display("FAIL wrap_reuse got v=%b pc=%h ok=%b expected 1/200/1", upd_valid, upd_pc, upd_correct);
        end
    endtask

    task automatic test_mispredict();
        push_one(26'h500, 1'b1, 4'b0110);
        push_one(26'h504, 1'b0, 4'b1101);
        push_one(26'h508, 1'b1, 4'b1011);
        res_valid = 1'b1; res_taken = 1'b0;
        pred_valid = 1'b1; pred_pc = 26'h3FF; pred_taken = 1'b1; pred_hist = 4'h9;
        step();
        idle_inputs();
        checks++;
        if ({upd_valid, upd_correct, mispredict, recover_hist, count, upd_pred_taken}
            !== {1'b1, 1'b0, 1'b1, 4'b1100, 3'd0, 1'b1}) begin
            failures++;
            $display("FAIL mispredict got v=%b ok=%b misp=%b rh=%b count=%0d pt=%b expected 1/0/1/1100/0/1",
                     upd_valid, upd_correct, mispredict, recover_hist, count, upd_pred_taken);
        end
        step();
        checks++;
        if ({count, mispredict, upd_valid} !== {3'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL mispredict_after got count=%0d misp=%b v=%b expected 0/0/0", count, mispredict, upd_valid);
        end
        push_one(26'h600, 1'b0, 4'h1);
        res_valid = 1'b1; res_taken = 1'b0;
        step();
        res_valid = 1'b0;
        checks++;
        if ({upd_valid, upd_pc, count} !== {1'b1, 26'h600, 3'd0}) begin
            failures++;
            $display("FAIL post_flush_push got v=%b pc=%h count=%0d expected 1/600/0", upd_valid, upd_pc, count);
        end
    endtask

    task automatic test_empty_resolve();
        res_valid = 1'b1; res_taken = 1'b1;
        step();
        res_valid = 1'b0;
        checks++;
        if ({res_err, upd_valid, count} !== {1'b1, 1'b0, 3'd0}) begin
            failures++;
            $display("FAIL empty_resolve got err=%b v=%b count=%0d expected 1/0/0", res_err, upd_valid, count);
        end
        step();
        checks++;
        if (res_err !== 1'b0) begin
            failures++;
            $display("FAIL empty_err_pulse got err=%b expected 0", res_err);
        end
    endtask

    task automatic test_flush_reset();
        push_one(26'h700, 1'b1, 4'h2);
        push_one(26'h704, 1'b1, 4'h4);
        flush = 1'b1; res_valid = 1'b1; res_taken = 1'b1;
        pred_valid = 1'b1; pred_pc = 26'h708;
        step();
        idle_inputs();
        checks++;
        if ({upd_valid, count, res_err} !== {1'b0, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL flush got v=%b count=%0d err=%b expected 0/0/0", upd_valid, count, res_err);
        end
        push_one(26'h710, 1'b1, 4'h8);
        res_valid = 1'b1; res_taken = 1'b1;
        step();
        res_valid = 1'b0;
        checks++;
        if ({upd_valid, upd_pc} !== {1'b1, 26'h710}) begin
            failures++;
            $display("FAIL flush_then_push got v=%b pc=%h expected 1/710", upd_valid, upd_pc);
        end
        for (int i = 0; i < 3; i++) push_one(26'h720 + 26'(i), 1'b1, 4'hA);
        rst = 1'b1; flush = 1'b1; res_valid = 1'b1; res_taken = 1'b0;
        step();
        idle_inputs();
        checks++;
        if ({count, upd_valid, upd_pc, upd_pred_taken, upd_correct, mispredict, recover_hist, res_err}
            !== {3'd0, 1'b0, 26'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0}) begin
            failures++;
            $display("FAIL mid_reset got count=%0d v=%b pc=%h pt=%b ok=%b misp=%b rh=%h err=%b expected all 0",
                     count, upd_valid, upd_pc, upd_pred_taken, upd_correct, mispredict, recover_hist, res_err);
        end
    endtask

    task automatic test_random();
        model_ent_t mq[$];
        model_ent_t e;
        logic exp_v, exp_ok, exp_misp, exp_err, exp_pt;
        logic [ADDR_WIDTH-1:0] exp_pc;
        logic [HIST_WIDTH-1:0] exp_rh;
        int n_before;
        for (int cyc = 0; cyc < 400; cyc++) begin
            pred_valid = ($urandom_range(0, 99) < 60);
            pred_pc    = ADDR_WIDTH'($urandom);
            pred_taken = 1'($urandom);
            pred_hist  = HIST_WIDTH'($urandom);
            res_valid  = ($urandom_range(0, 99) < 45);
            res_taken  = ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0;
            flush      = ($urandom_range(0, 99) < 3);
            #1;
            checks++;
            if (pred_ready !== (mq.size() < DEPTH)) begin
                failures++;
                $display("FAIL rand_ready cyc=%0d got %b expected %b", cyc, pred_ready, mq.size() < DEPTH);
            end
            exp_v = 0; exp_ok = 0; exp_misp = 0; exp_err = 0; exp_pt = 0; exp_pc = '0; exp_rh = '0;
            n_before = mq.size();
            if (flush) begin
                mq.delete();
            end else begin
                if (res_valid && n_before == 0) exp_err = 1;
                if (res_valid && n_before > 0) begin
                    e = mq.pop_front();
                    exp_v  = 1;
                    exp_pc = e.pc;
                    exp_pt = e.taken;
                    exp_ok = (e.taken == res_taken);
                    exp_misp = !exp_ok;
                    exp_rh = HIST_WIDTH'({e.hist, res_taken});
                    if (exp_misp) mq.delete();
                end
                if (pred_valid && n_before < DEPTH && !exp_misp)
                    mq.push_back('{pc: pred_pc, taken: pred_taken, hist: pred_hist});
            end
            step();
            checks++;
            if ({upd_valid, mispredict, res_err, count} !== {exp_v, exp_misp, exp_err, 3'(mq.size())}) begin
                failures++;
                $display("FAIL rand_ctrl cyc=%0d got v=%b misp=%b err=%b count=%0d expected %b/%b/%b/%0d",
                         cyc, upd_valid, mispredict, res_err, count, exp_v, exp_misp, exp_err, mq.size());
            end
            if (exp_v) begin
                checks++;
                if ({upd_pc, upd_pred_taken, upd_correct} !== {exp_pc, exp_pt, exp_ok}) begin
                    failures++;
                    $display("FAIL rand_data cyc=%0d got pc=%h pt=%b ok=%b expected pc=%h pt=%b ok=%b",
                             cyc, upd_pc, upd_pred_taken, upd_correct, exp_pc, exp_pt, exp_ok);
                end
            end
            if (exp_misp) begin
                checks++;
                if (recover_hist !== exp_rh) begin
                    failures++;
                    $display("FAIL rand_recover cyc=%0d got %b expected %b", cyc, recover_hist, exp_rh);
                end
            end
            #1;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_wrap();
        test_mispredict();
        test_empty_resolve();
        test_flush_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
